// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling, feeding a first-word-fallthrough byte FIFO.
// Latency: a byte is visible on rx_data/rx_valid one cycle after its stop-bit sample edge.
// Backpressure: a full FIFO drops the new byte and sets overrun, unless a pop happens in that cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 347,
  parameter int DEPTH        = 8,
  parameter int LW           = $clog2(DEPTH) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          ser_rx,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [LW-1:0] rx_level,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overrun,
  input  logic          err_clear
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam int            AW       = LW - 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_t;

  state_t        state, state_nxt;
  logic          sync1, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          sample_bit, push, frame_bad;

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      rxs   <= sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the sample/push/error strobes of the current cycle.
  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    push       = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE:    if (!rxs) state_nxt = S_START;
      S_START:   if (cnt == CNT_HALF) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt == CNT_FULL) begin
          sample_bit = 1'b1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_FULL) begin
          if (rxs) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = S_RECOVER;
          end
        end
      end
      S_RECOVER: if (rxs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (state_nxt != state || sample_bit) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
      if (state == S_START && state_nxt == S_DATA) idx <= '0;
      else if (sample_bit)                         idx <= idx + 1'b1;
      if (sample_bit) shreg <= {rxs, shreg[7:1]};
    end
  end

  assign rx_busy  = (state != S_IDLE);
  assign rx_level = wr_ptr - rd_ptr;
  assign rx_valid = (rx_level != '0);
  assign rx_data  = mem[rd_ptr[AW-1:0]];
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign push_ok  = push & ((rx_level != LVL_FULL) | pop);

  // FIFO storage and pointers; the extra pointer bit separates full from empty.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_bad)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (push & ~push_ok) overrun <= 1'b1;
      else if (err_clear)  overrun <= 1'b0;
    end
  end

endmodule
